// File: rtl/uart_hex_cmd_if.sv
// Byte stream in, parsed value out: the signals between uart_rx, the hex
// parser and the consumer of completed values.
interface uart_hex_cmd_if #(
  parameter int WIDTH = 32
) ();
  logic [7:0]       rx_data;
  logic             rx_strobe;
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             value_ready;
  logic             error;
  logic [1:0]       error_code;

  // master: byte source plus value consumer; slave: the parser
  modport master (
    output rx_data, rx_strobe, value_ready,
    input  value, value_valid, error, error_code
  );
  modport slave (
    input  rx_data, rx_strobe, value_ready,
    output value, value_valid, error, error_code
  );
endinterface

// File: rtl/uart_hex_cmd.sv
// ASCII hex line parser: accumulates hex digits per line, publishes the value
// on CR/LF over valid/ready, and pulses error on malformed input.
module uart_hex_cmd #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_hex_cmd_if.slave bus
);
  localparam int MAXDIG = WIDTH / 4;
  localparam int CW     = $clog2(MAXDIG + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISCARD} state_e;

  localparam logic [1:0] E_NONE     = 2'd0;
  localparam logic [1:0] E_ILLEGAL  = 2'd1;
  localparam logic [1:0] E_OVERFLOW = 2'd2;
  localparam logic [1:0] E_OVERRUN  = 2'd3;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic             is_digit, is_term, pub_ok;
  logic [3:0]       nib;

  // Character classification; letters map to 10..15 regardless of case
  always_comb begin
    is_digit = 1'b0;
    nib      = 4'd0;
    is_term  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_digit = 1'b1;
      nib      = bus.rx_data[3:0];
    end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      is_digit = 1'b1;
      nib      = bus.rx_data[3:0] + 4'd9;
    end
  end

  // A slot is free when nothing is pending or the pending value leaves now
  assign pub_ok = !valid_q || bus.value_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = valid_q && !bus.value_ready;
    err_d   = 1'b0;
    code_d  = E_NONE;
    if (bus.rx_strobe) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            acc_d   = WIDTH'(nib);
            cnt_d   = CW'(1);
            state_d = S_ACCUM;
          end else if (!is_term) begin
            err_d   = 1'b1;
            code_d  = E_ILLEGAL;
            state_d = S_DISCARD;
          end
        end
        S_ACCUM: begin
          if (is_digit) begin
            if (cnt_q == CW'(MAXDIG)) begin
              err_d   = 1'b1;
              code_d  = E_OVERFLOW;
              state_d = S_DISCARD;
            end else begin
              acc_d = (acc_q << 4) | WIDTH'(nib);
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_term) begin
            if (pub_ok) begin
              value_d = acc_q;
              valid_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = E_OVERRUN;
            end
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            code_d  = E_ILLEGAL;
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (is_term) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= E_NONE;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.error       = err_q;
  assign bus.error_code  = code_q;
endmodule

// File: tb/tb_uart_hex_cmd.sv
// Bench for uart_hex_cmd: directed lines then random bytes, checked every
// cycle against a line-oriented reference model.
module tb_uart_hex_cmd;
  localparam int WIDTH  = 32;
  localparam int MAXDIG = WIDTH / 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_hex_cmd_if #(.WIDTH(WIDTH)) bus ();
  uart_hex_cmd #(.WIDTH(WIDTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference state: bytes of the current line and the expected output regs
  logic [7:0]       line_q[$];
  logic [WIDTH-1:0] m_value;
  bit               m_valid;
  bit               m_err;
  logic [1:0]       m_code;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nib_of(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic bit is_term(input logic [7:0] c);
    return c == 8'h0D || c == 8'h0A;
  endfunction

  // A line prefix is still well-formed if it is all digits and fits
  function automatic bit line_clean();
    if (line_q.size() > MAXDIG) return 1'b0;
    foreach (line_q[i]) if (nib_of(line_q[i]) < 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] line_value();
    logic [63:0] v = 0;
    foreach (line_q[i]) v = v * 16 + 64'(nib_of(line_q[i]));
    return v[WIDTH-1:0];
  endfunction

  task automatic step(input bit s, input logic [7:0] d, input bit r);
    bit               pub;
    logic [WIDTH-1:0] v;
    bus.rx_strobe   = s;
    bus.rx_data     = d;
    bus.value_ready = r;
    pub    = 0;
    v      = '0;
    m_err  = 0;
    m_code = 0;
    if (s) begin
      if (is_term(d)) begin
        if (line_q.size() > 0 && line_clean()) begin
          pub = 1;
          v   = line_value();
        end
        line_q.delete();
      end else begin
        if (line_clean()) begin
          if (nib_of(d) < 0) begin
            m_err = 1; m_code = 2'd1;
          end else if (line_q.size() == MAXDIG) begin
            m_err = 1; m_code = 2'd2;
          end
        end
        line_q.push_back(d);
      end
    end
    if (pub) begin
      if (!m_valid || r) begin
        m_value = v;
        m_valid = 1;
      end else begin
        m_err = 1; m_code = 2'd3;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("value_valid", 64'(bus.value_valid), 64'(m_valid));
    chk("value", 64'(bus.value), 64'(m_value));
    chk("error", 64'(bus.error), 64'(m_err));
    chk("error_code", 64'(bus.error_code), 64'(m_code));
  endtask

  task automatic send_str(input string s, input bit r, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i], r);
      repeat (gap) step(1'b0, 8'h00, r);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.rx_strobe = 1'b0;
    line_q.delete();
    m_value = '0;
    m_valid = 0;
    #1;
    chk("rst_value", 64'(bus.value), 64'd0);
    chk("rst_valid", 64'(bus.value_valid), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_code", 64'(bus.error_code), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_char();
    int r = int'($urandom_range(0, 99));
    int n;
    if (r < 70) begin
      n = int'($urandom_range(0, 15));
      if (n < 10) return 8'(48 + n);
      return 8'(($urandom_range(0, 1) != 0 ? 65 : 97) + n - 10);
    end
    if (r < 85) return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bus.rx_data     = 8'h00;
    bus.rx_strobe   = 1'b0;
    bus.value_ready = 1'b0;
    m_value = '0;
    m_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Short line, widely spaced bytes, consumer always ready
    send_str("1F\r\n", 1'b1, 9);

    // Held value until the consumer finally accepts
    send_str("dEaDbEeF\n", 1'b0, 0);
    repeat (50) step(1'b0, 8'h00, 1'b0);
    chk("deadbeef_held", 64'(bus.value), 64'hDEADBEEF);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Digit overflow, then recovery
    send_str("123456789\n", 1'b1, 1);
    send_str("7\n", 1'b1, 1);
    chk("recover_7", 64'(bus.value), 64'h7);

    // Illegal character discards the remainder of the line
    send_str("4G2\n", 1'b1, 2);

    // Overrun with nobody consuming
    send_str("A\nB\n", 1'b0, 1);
    chk("overrun_keeps_A", 64'(bus.value), 64'hA);
    step(1'b0, 8'h00, 1'b1);
    // Acceptance coinciding with the second publish
    send_str("A\nB", 1'b0, 1);
    step(1'b1, 8'h0A, 1'b1);
    chk("same_cycle_B", 64'(bus.value), 64'hB);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset in the middle of a line loses the partial input
    send_str("AB", 1'b1, 1);
    do_reset();
    send_str("\n", 1'b1, 3);

    // Random byte stream with random gaps and random consumer readiness
    repeat (3000) begin
      step(1'b1, rand_char(), $urandom_range(0, 1) != 0);
      repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, $urandom_range(0, 1) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_hex_cmd.md
# uart_hex_cmd

Receive-side ASCII hex command parser for the FTDI serial console. It consumes the byte/strobe stream produced by the UART receiver and accumulates hexadecimal digits into a binary value. It presents each completed line as one value to user logic over a valid/ready handshake, and reports malformed input with a one-cycle error pulse. It sits between `uart_rx` and board logic (LEDs, registers), and is the inverse of the design's ASCII-digit transmit path.

## Interface
- `WIDTH`, 32: output value width in bits; must be a multiple of 4, range 4..64; `MAXDIG = WIDTH/4`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock domain; deassertion is synchronised externally.
- `rx_data`  in  8  received byte; sampled only when `rx_strobe` is high.
- `rx_strobe`  in  1  one-cycle byte-valid pulse; may be high on consecutive cycles.
- `value`  out  WIDTH  parsed value; stable while `value_valid` is high.
- `value_valid`  out  1  a parsed value is pending.
- `value_ready`  in  1  consumer accepts `value` when high together with `value_valid`.
- `error`  out  1  one-cycle pulse on a parse fault.
- `error_code`  out  2  fault cause; valid only while `error` is high. 1 = illegal character, 2 = digit overflow, 3 = output overrun.

## Operation
- Character classes, evaluated only on `rx_strobe`:
  - Digit: `0x30-0x39`, `0x41-0x46`, `0x61-0x66`; nibble value 0-15, case-insensitive.
  - Terminator: CR `0x0D` or LF `0x0A`.
  - Illegal: everything else.
- Internal state: accumulator `acc[WIDTH-1:0]`, digit counter `cnt` (0..MAXDIG), FSM with three states.
- State **IDLE** (`cnt==0`, `acc==0`):
  - Digit: `acc <= nibble`, `cnt <= 1`, go to ACCUM.
  - Terminator: ignored, so CRLF and blank lines produce nothing.
  - Illegal: error code 1, go to DISCARD.
- State **ACCUM**:
  - Digit with `cnt < MAXDIG`: `acc <= {acc[WIDTH-5:0], nibble}`, `cnt++`.
  - Digit with `cnt == MAXDIG`: error code 2, go to DISCARD.
  - Terminator: publish `acc` (see below), clear `acc` and `cnt`, go to IDLE.
  - Illegal: error code 1, go to DISCARD.
- State **DISCARD**:
  - All bytes are dropped with no further errors.
  - Terminator: clear `acc` and `cnt`, go to IDLE. No value is published.
- Publish rule:
  - If `value_valid` is low, or the pending value is accepted in that same cycle (`value_valid && value_ready`): `value <= acc`, `value_valid <= 1`.
  - Otherwise: the new value is dropped, the old `value` is kept, error code 3 is raised, and the FSM still returns to IDLE.
- Handshake:
  - `value_valid` deasserts the cycle after acceptance unless a new publish occurs in the same cycle.
  - `value` must not change while `value_valid` is high and not yet accepted.
- Parsing continues while a value is pending, so the accumulator is independent of the `value` register.
- Fewer than MAXDIG digits zero-extend: "A5" gives `0x...0A5`.
- Reset mid-line: all state is lost. After release the parser is in IDLE, so partial input before reset never produces a value.

## Timing
- Reset values:
  - `value = 0`, `value_valid = 0`, `error = 0`, `error_code = 0`.
  - FSM in IDLE, `acc = 0`, `cnt = 0`.
- Latency:
  - Terminator strobe in cycle N gives `value_valid` high in cycle N+1.
  - Faulting byte in cycle N gives `error` high for exactly cycle N+1.
- One byte per cycle is sustained; there are no stall paths and no back-pressure toward `rx_strobe`.
- `error` is high for at most one cycle per faulting byte. `error_code` returns to 0 when `error` is low.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- "1F\r\n" as single-cycle strobes 10 cycles apart, `value_ready=1`, `WIDTH=32` -> `value=0x0000001F`; `value_valid` high for exactly 1 cycle, starting the cycle after the CR strobe; LF produces nothing; no `error`.
- "dEaDbEeF\n" with `value_ready=0` -> `value=0xDEADBEEF` held with `value_valid` high. Raise `value_ready` 50 cycles later -> accepted, `value_valid` low the next cycle.
- "123456789\n" (9 digits, `WIDTH=32`) -> `error` pulse with code 2 on the 9th digit, no value. Follow with "7\n" -> `value=0x7`.
- "4G2\n" -> code 1 pulse one cycle after the 'G' strobe; the '2' and LF are discarded silently; no value published.
- "A\n" then "B\n" with `value_ready=0` -> `value=0xA` retained and code 3 pulse after the second LF. Repeat with `value_ready=1` pulsed in the same cycle as the second publish -> `value=0xB`, no error.
- Assert `reset_n=0` after "AB" with no terminator, release, then send "\n" -> no value, no error, all outputs 0.
